// File: rtl/adder.sv
// Full adder with a registered copy and an optional LSB-first serial word accumulator.
// The serial accumulator is compiled in only when ADDER_SERIAL_EN is defined.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             ci,
    output logic             S,
    output logic             co,
    input  logic             in_valid,
    output logic             s_q,
    output logic             co_q,
    output logic             out_valid,
    input  logic             ser_en,
    input  logic             ser_clr,
    output logic [WIDTH-1:0] ser_word,
    output logic             ser_carry,
    output logic             ser_done
);

    // Reset release is retimed through run_q, so the first update lands on the second edge.
    logic run_q;

    always_comb begin
        S  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            co_q      <= 1'b0;
            out_valid <= 1'b0;
        end else if (run_q) begin
            out_valid <= in_valid;
            if (in_valid) begin
                s_q  <= S;
                co_q <= co;
            end
        end
    end

`ifdef ADDER_SERIAL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    bit_cnt;
    logic             carry_q;
    logic [WIDTH-1:0] shift_q;
    logic             step;
    logic             last;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] shift_nxt;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        step      = in_valid & ser_en;
        last      = (bit_cnt == CW'(WIDTH - 1));
        sum_bit   = a ^ b ^ carry_q;
        carry_nxt = (a & b) | (a & carry_q) | (b & carry_q);
        shift_nxt = {sum_bit, shift_q[WIDTH-1:1]};
    end

    // NOTE: the shift register is reset with the control state so a partial word never survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            carry_q   <= 1'b0;
            shift_q   <= '0;
            ser_word  <= '0;
            ser_carry <= 1'b0;
            ser_done  <= 1'b0;
        end else if (run_q) begin
            ser_done <= 1'b0;
            if (ser_clr) begin
                bit_cnt <= '0;
                carry_q <= 1'b0;
                shift_q <= '0;
            end else if (step) begin
                if (last) begin
                    ser_word  <= shift_nxt;
                    ser_carry <= carry_nxt;
                    ser_done  <= 1'b1;
                    bit_cnt   <= '0;
                    carry_q   <= 1'b0;
                    shift_q   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    carry_q <= carry_nxt;
                    shift_q <= shift_nxt;
                end
            end
        end
    end
`else
    logic unused_ser;

    assign unused_ser = ser_en ^ ser_clr;
    assign ser_word   = '0;
    assign ser_carry  = 1'b0;
    assign ser_done   = 1'b0;
`endif

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: randomized stimulus against a word-level arithmetic model,
// plus literal expectations for the truth table, registered path and serial words.
module tb_adder;

    localparam int WIDTH = 8;
`ifdef ADDER_SERIAL_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             a;
    logic             b;
    logic             ci;
    logic             S;
    logic             co;
    logic             in_valid;
    logic             s_q;
    logic             co_q;
    logic             out_valid;
    logic             ser_en;
    logic             ser_clr;
    logic [WIDTH-1:0] ser_word;
    logic             ser_carry;
    logic             ser_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .S(S), .co(co),
        .in_valid(in_valid), .s_q(s_q), .co_q(co_q), .out_valid(out_valid),
        .ser_en(ser_en), .ser_clr(ser_clr), .ser_word(ser_word),
        .ser_carry(ser_carry), .ser_done(ser_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: the serial word is the integer sum of the collected a and b bits.
    bit     m_run, m_sq, m_coq, m_ov, m_done, m_carry;
    int     m_cnt;
    longint m_a, m_b, m_word;

    task automatic model_reset();
        m_run = 0; m_sq = 0; m_coq = 0; m_ov = 0; m_done = 0; m_carry = 0;
        m_cnt = 0; m_a = 0; m_b = 0; m_word = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            m_run = 1;
        end else begin
            int t;
            t = int'(a) + int'(b) + int'(ci);
            m_ov = in_valid;
            if (in_valid) begin
                m_sq  = t[0];
                m_coq = t[1];
            end
            if (SER) begin
                m_done = 0;
                if (ser_clr) begin
                    m_cnt = 0; m_a = 0; m_b = 0;
                end else if (in_valid && ser_en) begin
                    m_a = m_a | (longint'(a) << m_cnt);
                    m_b = m_b | (longint'(b) << m_cnt);
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        longint sum;
                        sum     = m_a + m_b;
                        m_word  = sum % (longint'(1) << WIDTH);
                        m_carry = (sum >> WIDTH) != 0;
                        m_done  = 1;
                        m_cnt = 0; m_a = 0; m_b = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int t;
            t = int'(a) + int'(b) + int'(ci);
            check("S", 32'(S), 32'(t % 2));
            check("co", 32'(co), 32'(t / 2));
            check("s_q", 32'(s_q), 32'(m_sq));
            check("co_q", 32'(co_q), 32'(m_coq));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("ser_word", 32'(ser_word), 32'(m_word));
            check("ser_carry", 32'(ser_carry), 32'(m_carry));
            check("ser_done", 32'(ser_done), 32'(m_done));
        end
    end

    task automatic drive(input logic va, input logic vb, input logic vci,
                         input logic vv, input logic ven, input logic vclr);
        @(posedge clk);
        #2;
        a = va; b = vb; ci = vci; in_valid = vv; ser_en = ven; ser_clr = vclr;
    endtask

    task automatic feed_word(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb);
        for (int i = 0; i < WIDTH; i++) begin
            drive(wa[i], wb[i], 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic truth_table(input string tag);
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        s_tab = 8'b1001_0110;
        c_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            drive(i[2], i[1], i[0], 1'b0, 1'b0, 1'b0);
            #1;
            check({tag, "_S"}, 32'(S), 32'(s_tab[i]));
            check({tag, "_co"}, 32'(co), 32'(c_tab[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; a = 0; b = 0; ci = 0; in_valid = 0; ser_en = 0; ser_clr = 0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        truth_table("tt_rst");
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ser_word", 32'(ser_word), 32'd0);

        // Release with a valid 1+1 pending: nothing updates on the first edge.
        @(posedge clk);
        #2;
        rst_n = 1'b1; a = 1; b = 1; ci = 0; in_valid = 1;
        @(posedge clk);
        #2;
        check("sync_edge1_ov", 32'(out_valid), 32'd0);
        check("sync_edge1_coq", 32'(co_q), 32'd0);
        @(posedge clk);
        #2;
        check("reg_ov", 32'(out_valid), 32'd1);
        check("reg_sq", 32'(s_q), 32'd0);
        check("reg_coq", 32'(co_q), 32'd1);
        in_valid = 0; a = 0; b = 1;
        @(posedge clk);
        #2;
        check("reg_hold_ov", 32'(out_valid), 32'd0);
        check("reg_hold_sq", 32'(s_q), 32'd0);
        check("reg_hold_coq", 32'(co_q), 32'd1);

        truth_table("tt_run");

        feed_word(8'hA5, 8'h5B);
        drive(0, 0, 0, 0, 0, 0);
        check("w1_done", 32'(ser_done), 32'(SER));
        check("w1_word", 32'(ser_word), 32'h00);
        check("w1_carry", 32'(ser_carry), 32'(SER));
        drive(0, 0, 0, 0, 0, 0);
        check("w1_done_pulse", 32'(ser_done), 32'd0);
        check("w1_carry_hold", 32'(ser_carry), 32'(SER));

        feed_word(8'hA5, 8'h5B);
        feed_word(8'h01, 8'h01);
        drive(0, 0, 0, 0, 0, 0);
        check("w2_word", 32'(ser_word), SER ? 32'h02 : 32'h00);
        check("w2_carry", 32'(ser_carry), 32'd0);

        // Three bits, then a reset pulse discards the partial word.
        feed_word(8'hFF, 8'h01);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 0;
        #1;
        check("mid_rst_word", 32'(ser_word), 32'd0);
        check("mid_rst_carry", 32'(ser_carry), 32'd0);
        check("mid_rst_coq", 32'(co_q), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        feed_word(8'h3C, 8'h0F);
        drive(0, 0, 0, 0, 0, 0);
        check("post_rst_word", 32'(ser_word), SER ? 32'h4B : 32'h00);

        // Three bits, then ser_clr on a valid step: that bit is dropped, outputs keep 0x4B.
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 1, 0);
        drive(1, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("clr_done", 32'(ser_done), 32'd0);
        check("clr_word", 32'(ser_word), SER ? 32'h4B : 32'h00);
        feed_word(8'h80, 8'h80);
        drive(0, 0, 0, 0, 0, 0);
        check("post_clr_word", 32'(ser_word), 32'h00);
        check("post_clr_carry", 32'(ser_carry), 32'(SER));

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 8, serial word length in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  1  addend bit.
REQ-005 b  input  1  addend bit.
REQ-006 ci  input  1  carry-in bit for the combinational path.
REQ-007 S  output  1  combinational sum bit.
REQ-008 co  output  1  combinational carry-out bit.
REQ-009 in_valid  input  1  qualifies a, b and ci for the registered and serial paths.
REQ-010 s_q  output  1  registered sum.
REQ-011 co_q  output  1  registered carry-out.
REQ-012 out_valid  output  1  s_q and co_q were updated on the last edge.
REQ-013 ser_en  input  1  routes qualified a/b bits into the serial accumulator.
REQ-014 ser_clr  input  1  synchronous clear of the serial accumulator.
REQ-015 ser_word  output  WIDTH  last completed serial sum word.
REQ-016 ser_carry  output  1  final carry of the last completed serial word.
REQ-017 ser_done  output  1  one-cycle pulse when a serial word completes.

Function
REQ-018 S SHALL equal a XOR b XOR ci, and co SHALL equal (a AND b) OR (a AND ci) OR (b AND ci).
REQ-019 S and co SHALL be purely combinational, with zero latency, and independent of clk and rst_n, including while reset is asserted.
REQ-020 Registered path: on each edge with in_valid=1, s_q<=S and co_q<=co; with in_valid=0, s_q and co_q hold.
REQ-021 out_valid SHALL be in_valid delayed by exactly one cycle.
REQ-022 Serial accumulation step (in_valid=1 and ser_en=1):
- sum bit = a XOR b XOR carry register; ci is ignored.
- carry register <= majority(a, b, carry register).
- sum bit shifts into the internal shift register at the MSB, shifting right, so the word is sent LSB first.
- bit counter increments.
REQ-023 Word completion: when the WIDTH-th step is accepted:
- ser_word <= completed shift contents, including the current bit.
- ser_carry <= carry-out of that step.
- ser_done = 1 for exactly the following cycle.
- bit counter wraps to 0 and carry register clears to 0.
REQ-024 ser_word and ser_carry SHALL hold between completions.
REQ-025 Steps with in_valid=0 or ser_en=0 SHALL leave all serial state unchanged.
REQ-026 ser_clr=1 SHALL clear the bit counter, carry register and shift register, but not ser_word or ser_carry.
REQ-027 ser_clr SHALL have priority over a simultaneous serial step; that step's bit is discarded and ser_done stays 0.
REQ-028 The registered path SHALL operate regardless of ser_en.

Reset
REQ-029 rst_n=0 SHALL immediately force all of the following to 0: s_q, co_q, out_valid, ser_word, ser_carry, ser_done, bit counter, carry register and shift register.
REQ-030 Reset asserted mid-word SHALL discard the partial word; the first step after release is bit 0 with carry 0.
REQ-031 Release SHALL be synchronised internally so the first register update occurs on the second rising clk edge after rst_n rises.

Configuration
REQ-032 Macro ADDER_SERIAL_EN:
- Defined: serial accumulator (REQ-022..REQ-027) compiled in.
- Undefined: serial logic absent; ser_word, ser_carry and ser_done tied to 0; ser_en and ser_clr ignored.
- Port list is identical in both builds.

Verification
REQ-033 Truth table, combinational outputs:
- a,b,ci = 0,0,0 -> S=0, co=0.
- 1,0,0 -> S=1, co=0.
- 1,1,0 -> S=0, co=1.
- 1,1,1 -> S=1, co=1.
- All 8 combinations checked exhaustively, both during and after reset.
REQ-034 Registered path: a=1, b=1, ci=0, in_valid=1 for one cycle -> next cycle s_q=0, co_q=1, out_valid=1; following cycle out_valid=0 and s_q/co_q hold.
REQ-035 Serial, WIDTH=8, ADDER_SERIAL_EN defined: A=0xA5 and B=0x5B fed LSB first over 8 consecutive valid cycles -> ser_word=0x00, ser_carry=1, ser_done high one cycle.
REQ-036 Serial completion immediately followed by 0x01+0x01 -> ser_word=0x02, ser_carry=0, so no carry leaks between words.
REQ-037 Interrupted words:
- rst_n pulsed low after 3 serial bits -> all outputs 0; a full new word then sums correctly from bit 0.
- Repeat with ser_clr=1 coincident with a valid step -> no ser_done; that bit is discarded; ser_word and ser_carry retain their prior values.
REQ-038 Build with ADDER_SERIAL_EN undefined, same stimulus as REQ-035 -> ser_word=0, ser_carry=0, ser_done never asserts; S/co and the registered path are unaffected.
